// File: rtl/player_cell_updater.sv
// player_cell_updater
//   Keeps the player's cell in the tile RAM in step with the player position.
//   After reset or a game-reset request, it repaints the whole playfield: row 1
//   becomes goal tiles and every other row becomes empty tiles. It then draws
//   the player. When the position changes, it restores the old cell to its
//   background and draws the new cell. It acknowledges each completed draw
//   with a one-cycle pulse.
//
// Ports
//   i_Clk           rising-edge clock
//   i_reset         synchronous, active-high reset
//   i_game_reset    abort current work and repaint the playfield
//   i_player_x/y    current player column (1..GRID_W) / row (1..GRID_H)
//   i_wr_ready      tile-RAM accepts the write presented this cycle
//   o_wr_en         tile-RAM write request (held with addr/data until accepted)
//   o_wr_addr       tile address, (y-1)*GRID_W + (x-1)
//   o_wr_data       tile code: 00 empty, 01 player, 10 goal
//   o_player_moved  one-cycle acknowledge of a completed draw
//   o_busy          high whenever the FSM is not idle
module player_cell_updater #(
  parameter int GRID_W = 20,
  parameter int GRID_H = 15
) (
  input  logic       i_Clk,
  input  logic       i_reset,
  input  logic       i_game_reset,
  input  logic [4:0] i_player_x,
  input  logic [3:0] i_player_y,
  input  logic       i_wr_ready,
  output logic       o_wr_en,
  output logic [8:0] o_wr_addr,
  output logic [1:0] o_wr_data,
  output logic       o_player_moved,
  output logic       o_busy
);

  typedef enum logic [2:0] {IDLE, CLEAR, ERASE, DRAW, ACK} state_t;

  localparam logic [4:0] W5   = 5'(GRID_W);
  localparam logic [3:0] H4   = 4'(GRID_H);
  localparam logic [8:0] W9   = 9'(GRID_W);
  localparam logic [8:0] LAST = 9'(GRID_W * GRID_H - 1);

  localparam logic [1:0] T_EMPTY  = 2'b00;
  localparam logic [1:0] T_PLAYER = 2'b01;
  localparam logic [1:0] T_GOAL   = 2'b10;

  function automatic logic [8:0] cell_addr(input logic [4:0] x, input logic [3:0] y);
    return ({5'd0, y} - 9'd1) * W9 + ({4'd0, x} - 9'd1);
  endfunction

  state_t     r_state;
  logic       r_need_clear;
  logic [8:0] r_clr_addr;
  logic [4:0] r_drawn_x;
  logic [3:0] r_drawn_y;
  logic       r_drawn_valid;
  logic [4:0] r_tgt_x;
  logic [3:0] r_tgt_y;

  logic       w_in_range;
  logic [8:0] w_in_addr;
  logic       w_moved;
  logic       w_wr_done;
  logic [8:0] w_drawn_addr;
  logic [1:0] w_erase_data;
  logic [8:0] w_clr_next;

  assign w_in_range   = (i_player_x != 5'd0) && (i_player_x <= W5) &&
                        (i_player_y != 4'd0) && (i_player_y <= H4);
  assign w_in_addr    = cell_addr(i_player_x, i_player_y);
  assign w_moved      = (i_player_x != r_drawn_x) || (i_player_y != r_drawn_y);
  assign w_wr_done    = o_wr_en && i_wr_ready;
  assign w_drawn_addr = cell_addr(r_drawn_x, r_drawn_y);
  assign w_erase_data = (r_drawn_y == 4'd1) ? T_GOAL : T_EMPTY;
  assign w_clr_next   = r_clr_addr + 9'd1;

  // Entry into DRAW presets the write. An out-of-range target leaves o_wr_en
  // low, so DRAW recognises the "no write" case from o_wr_en alone.
  always_ff @(posedge i_Clk) begin
    if (i_reset) begin
      r_state        <= IDLE;
      r_need_clear   <= 1'b1;
      r_clr_addr     <= '0;
      r_drawn_x      <= '0;
      r_drawn_y      <= '0;
      r_drawn_valid  <= 1'b0;
      r_tgt_x        <= '0;
      r_tgt_y        <= '0;
      o_wr_en        <= 1'b0;
      o_wr_addr      <= '0;
      o_wr_data      <= T_EMPTY;
      o_player_moved <= 1'b0;
      o_busy         <= 1'b0;
    end else if (i_game_reset) begin
      // CLEAR restarts with o_wr_en low. It raises the request for address 0
      // on its next cycle.
      r_state        <= CLEAR;
      r_need_clear   <= 1'b0;
      r_clr_addr     <= '0;
      o_wr_en        <= 1'b0;
      o_player_moved <= 1'b0;
      o_busy         <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_need_clear) begin
            r_need_clear <= 1'b0;
            r_clr_addr   <= '0;
            r_state      <= CLEAR;
            o_wr_en      <= 1'b1;
            o_wr_addr    <= '0;
            o_wr_data    <= T_GOAL;
            o_busy       <= 1'b1;
          end else if (r_drawn_valid && w_moved) begin
            r_tgt_x   <= i_player_x;
            r_tgt_y   <= i_player_y;
            r_state   <= ERASE;
            o_wr_en   <= 1'b1;
            o_wr_addr <= w_drawn_addr;
            o_wr_data <= w_erase_data;
            o_busy    <= 1'b1;
          end else if (!r_drawn_valid && w_in_range) begin
            r_tgt_x   <= i_player_x;
            r_tgt_y   <= i_player_y;
            r_state   <= DRAW;
            o_wr_en   <= 1'b1;
            o_wr_addr <= w_in_addr;
            o_wr_data <= T_PLAYER;
            o_busy    <= 1'b1;
          end
        end

        CLEAR: begin
          if (!o_wr_en) begin
            o_wr_en   <= 1'b1;
            o_wr_addr <= r_clr_addr;
            o_wr_data <= (r_clr_addr < W9) ? T_GOAL : T_EMPTY;
          end else if (w_wr_done) begin
            if (r_clr_addr == LAST) begin
              r_drawn_valid <= 1'b0;
              r_tgt_x       <= i_player_x;
              r_tgt_y       <= i_player_y;
              r_state       <= DRAW;
              o_wr_en       <= w_in_range;
              o_wr_addr     <= w_in_addr;
              o_wr_data     <= T_PLAYER;
            end else begin
              r_clr_addr <= w_clr_next;
              o_wr_addr  <= w_clr_next;
              o_wr_data  <= (w_clr_next < W9) ? T_GOAL : T_EMPTY;
            end
          end
        end

        ERASE: begin
          if (w_wr_done) begin
            r_tgt_x   <= i_player_x;
            r_tgt_y   <= i_player_y;
            r_state   <= DRAW;
            o_wr_en   <= w_in_range;
            o_wr_addr <= w_in_addr;
            o_wr_data <= T_PLAYER;
          end
        end

        DRAW: begin
          if (!o_wr_en) begin
            r_drawn_valid <= 1'b0;
            r_state       <= IDLE;
            o_busy        <= 1'b0;
          end else if (w_wr_done) begin
            r_drawn_x      <= r_tgt_x;
            r_drawn_y      <= r_tgt_y;
            r_drawn_valid  <= 1'b1;
            r_state        <= ACK;
            o_wr_en        <= 1'b0;
            o_player_moved <= 1'b1;
          end
        end

        ACK: begin
          o_player_moved <= 1'b0;
          r_state        <= IDLE;
          o_busy         <= 1'b0;
        end

        default: begin
          r_state        <= IDLE;
          o_wr_en        <= 1'b0;
          o_player_moved <= 1'b0;
          o_busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_cell_updater.sv
// tb_player_cell_updater
//   Directed scenarios plus randomized moves for player_cell_updater. The
//   reference model works at the transaction level. For each requested
//   position it predicts the list of tile writes and the expected pulse count.
//   It also predicts the final playfield image from the tile rules.
module tb_player_cell_updater;
  localparam int GW = 20;
  localparam int GH = 15;

  logic       clk = 1'b0;
  logic       rst, grst, rdy;
  logic [4:0] px;
  logic [3:0] py;
  logic       o_wr_en, o_player_moved, o_busy;
  logic [8:0] o_wr_addr;
  logic [1:0] o_wr_data;

  player_cell_updater #(.GRID_W(GW), .GRID_H(GH)) dut (
    .i_Clk(clk), .i_reset(rst), .i_game_reset(grst),
    .i_player_x(px), .i_player_y(py), .i_wr_ready(rdy),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_player_moved(o_player_moved), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed traffic: a write completes when en & ready are seen mid-cycle
  // and neither reset aborts it at the coming edge.
  int got_a[$], got_d[$], got_c[$];
  int pulses  = 0;
  int pulse_c = -1;
  int mem [GW*GH];

  always @(negedge clk) begin
    if (!rst && !grst) begin
      if (o_wr_en && rdy) begin
        got_a.push_back(int'(o_wr_addr));
        got_d.push_back(int'(o_wr_data));
        got_c.push_back(cyc);
        if (int'(o_wr_addr) < GW*GH) mem[int'(o_wr_addr)] = int'(o_wr_data);
      end
      if (o_player_moved) begin
        pulses++;
        pulse_c = cyc;
      end
    end
  end

  // Reference model
  int mx = 0, my = 0;
  bit mvalid = 1'b0;
  int ea[$], ed[$];
  int epulse = 0;

  function automatic int a_of(input int x, input int y);
    return (y - 1) * GW + (x - 1);
  endfunction

  function automatic bit inr(input int x, input int y);
    return (x >= 1) && (x <= GW) && (y >= 1) && (y <= GH);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_got();
    got_a.delete(); got_d.delete(); got_c.delete();
    pulses  = 0;
    pulse_c = -1;
  endtask

  task automatic predict_draw(input int x, input int y);
    if (inr(x, y)) begin
      ea.push_back(a_of(x, y)); ed.push_back(1);
      epulse = 1; mx = x; my = y; mvalid = 1'b1;
    end else begin
      mvalid = 1'b0;
    end
  endtask

  task automatic predict_move(input int x, input int y);
    ea.delete(); ed.delete(); epulse = 0;
    if (mvalid && (x != mx || y != my)) begin
      ea.push_back(a_of(mx, my)); ed.push_back(my == 1 ? 2 : 0);
      predict_draw(x, y);
    end else if (!mvalid && inr(x, y)) begin
      predict_draw(x, y);
    end
  endtask

  task automatic predict_clear(input int x, input int y);
    ea.delete(); ed.delete(); epulse = 0;
    for (int a = 0; a < GW*GH; a++) begin
      ea.push_back(a); ed.push_back(a < GW ? 2 : 0);
    end
    mvalid = 1'b0;
    predict_draw(x, y);
  endtask

  task automatic compare(input string tag);
    check({tag, "_nwrites"}, got_a.size(), ea.size());
    check({tag, "_pulses"}, pulses, epulse);
    for (int i = 0; i < ea.size() && i < got_a.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), got_a[i], ea[i]);
      check($sformatf("%s_data%0d", tag, i), got_d[i], ed[i]);
    end
  endtask

  task automatic wait_done(input int maxc, input bit rnd, output bit ok);
    bit seen;
    seen = 1'b0; ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk); #1;
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (o_busy) seen = 1'b1;
      else if (seen) begin ok = 1'b1; break; end
    end
    rdy = 1'b1;
  endtask

  task automatic do_move(input string tag, input int x, input int y, input bit rnd);
    bit ok;
    predict_move(x, y);
    clear_got();
    @(posedge clk); #1;
    px = 5'(x); py = 4'(y);
    if (ea.size() > 0) begin
      wait_done(200, rnd, ok);
      check({tag, "_done"}, int'(ok), 1);
    end else begin
      repeat (6) @(posedge clk);
      @(negedge clk);
    end
    compare(tag);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_en"}, int'(o_wr_en), 0);
    check({tag, "_addr"}, int'(o_wr_addr), 0);
    check({tag, "_data"}, int'(o_wr_data), 0);
    check({tag, "_pulse"}, int'(o_player_moved), 0);
    check({tag, "_busy"}, int'(o_busy), 0);
    check({tag, "_valid"}, int'(dut.r_drawn_valid), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int c0;
    int rx, ry, e;
    rst = 1'b1; grst = 1'b0; rdy = 1'b1; px = 5'd10; py = 4'd15;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outs("rst");

    // Reset: full repaint, then player at (10,15) -> addr 289
    clear_got();
    predict_clear(10, 15);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_done(700, 1'b0, ok);
    check("reset_done", int'(ok), 1);
    compare("reset");

    // Move up with fixed latency
    predict_move(10, 14);
    clear_got();
    @(posedge clk); #1;
    py = 4'd14;
    c0 = cyc;
    wait_done(20, 1'b0, ok);
    check("up_done", int'(ok), 1);
    compare("up");
    if (got_c.size() == 2) begin
      check("up_lat_erase", got_c[0] - c0, 1);
      check("up_lat_draw", got_c[1] - c0, 2);
    end
    check("up_lat_pulse", pulse_c - c0, 3);

    // Backpressure during ERASE: request held for 5 stalled cycles
    predict_move(11, 14);
    clear_got();
    @(posedge clk); #1;
    rdy = 1'b0; px = 5'd11;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_en%0d", i), int'(o_wr_en), 1);
      check($sformatf("bp_addr%0d", i), int'(o_wr_addr), a_of(10, 14));
      check($sformatf("bp_data%0d", i), int'(o_wr_data), 0);
      check($sformatf("bp_nwr%0d", i), got_a.size(), 0);
      @(posedge clk); #1;
    end
    wait_done(20, 1'b0, ok);
    check("bp_done", int'(ok), 1);
    compare("bp");

    // Goal row: erase of a row-1 cell restores the goal tile
    do_move("to_goal", 10, 1, 1'b0);
    do_move("from_goal", 10, 15, 1'b0);

    // Game reset during a stalled ERASE
    clear_got();
    @(posedge clk); #1;
    rdy = 1'b0; px = 5'd5; py = 4'd5;
    @(negedge clk);
    @(negedge clk);
    check("gr_stall_en", int'(o_wr_en), 1);
    check("gr_stall_addr", int'(o_wr_addr), a_of(10, 15));
    @(posedge clk); #1;
    grst = 1'b1;
    @(posedge clk); #1;
    grst = 1'b0; rdy = 1'b1;
    @(negedge clk);
    check("gr_en_drop", int'(o_wr_en), 0);
    check("gr_no_erase", got_a.size(), 0);
    predict_clear(5, 5);
    wait_done(700, 1'b0, ok);
    check("gr_done", int'(ok), 1);
    compare("gr");

    // Out of range: erase only, no draw, no pulse
    do_move("oor", 0, 5, 1'b0);
    check("oor_valid", int'(dut.r_drawn_valid), 0);
    do_move("redraw", 3, 3, 1'b0);

    // Reset mid-operation: pending write abandoned
    clear_got();
    @(posedge clk); #1;
    rdy = 1'b0; px = 5'd7; py = 4'd7;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outs("midrst");
    check("midrst_nwr", got_a.size(), 0);
    check("midrst_pulse", pulses, 0);
    predict_clear(7, 7);
    @(posedge clk); #1;
    rst = 1'b0; rdy = 1'b1;
    wait_done(700, 1'b0, ok);
    check("midrst_done", int'(ok), 1);
    compare("midrst");

    // Randomized moves with random backpressure
    for (int n = 0; n < 40; n++) begin
      e  = $urandom_range(0, 9);
      rx = (e == 0) ? 0 : (e == 1) ? $urandom_range(21, 31) : $urandom_range(1, GW);
      e  = $urandom_range(0, 9);
      ry = (e == 0) ? 0 : $urandom_range(1, GH);
      do_move($sformatf("rnd%0d", n), rx, ry, 1'b1);
    end

    // Final playfield image
    for (int a = 0; a < GW*GH; a++) begin
      e = (mvalid && a == a_of(mx, my)) ? 1 : (a < GW ? 2 : 0);
      check($sformatf("img%0d", a), mem[a], e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
